tremolo_rate_detect: RTL and testbench

TREMOLO_RATE_DETECT -- requirements
Module: tremolo_rate_detect

---
 rtl/tremolo_defs.sv | 19 +
 rtl/zero_run_detect.sv | 33 +++
 rtl/tremolo_rate_detect.sv | 95 +++++++++
 tb/tb_tremolo_rate_detect.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tremolo_defs.sv
// rtl/tremolo_defs.sv - shared widths and detector state encodings
package tremolo_defs;

  // Must track the tremolo effect's period register and audio sample widths.
  localparam int PERIOD_W = 25;
  localparam int AUDIO_W  = 24;

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } det_state_t;

  function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                   input logic [PERIOD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/zero_run_detect.sv
// rtl/zero_run_detect.sv - flags a run of MIN_ZERO consecutive silent samples
module zero_run_detect
  import tremolo_defs::*;
#(
  parameter int MIN_ZERO = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AUDIO_W-1:0] audio_in,
  output logic               run_done
);

  localparam int CW = $clog2(MIN_ZERO + 1);

  logic [CW-1:0] run_cnt;
  logic          is_zero;

  assign is_zero = (audio_in == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (!is_zero) begin
      run_cnt <= '0;
    end else if (run_cnt != CW'(MIN_ZERO)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // run_cnt counts zeros before this sample, so the current zero completes the run.
  assign run_done = is_zero && (run_cnt >= CW'(MIN_ZERO - 1));

endmodule

// File: rtl/tremolo_rate_detect.sv
// rtl/tremolo_rate_detect.sv - measures tremolo gating period from silent regions
module tremolo_rate_detect
  import tremolo_defs::*;
#(
  parameter int                  MIN_ZERO     = 64,
  parameter int                  TOL          = 16,
  parameter logic [PERIOD_W-1:0] INTERVAL_MAX = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AUDIO_W-1:0]  audio_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                locked,
  output logic                gated
);

  localparam logic [PERIOD_W-1:0] TOL_V = PERIOD_W'(TOL);

  det_state_t          state, state_nxt;
  logic [PERIOD_W-1:0] interval;
  logic                have_ref, have_prev;
  logic                run_done, on_edge, sat, timeout;

  zero_run_detect #(.MIN_ZERO(MIN_ZERO)) u_zero_run (
    .clk      (clk),
    .reset    (reset),
    .audio_in (audio_in),
    .run_done (run_done)
  );

  assign on_edge = (state == ST_OFF) && (audio_in != '0);
  assign sat     = (interval == INTERVAL_MAX);
  // A saturating count coinciding with an on-edge is a measurement, not a timeout.
  assign timeout = sat && !on_edge;
  assign gated   = (state == ST_OFF);

  always_comb begin
    state_nxt = state;
    if (run_done) begin
      state_nxt = ST_OFF;
    end else if (on_edge) begin
      state_nxt = ST_ON;
    end else if (timeout && state != ST_OFF) begin
      state_nxt = ST_SEEK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_SEEK;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      interval <= '0;
    end else if (on_edge) begin
      interval <= '0;
    end else if (!sat) begin
      interval <= interval + 1'b1;
    end
  end

  // have_prev gates the lock compare so a stale period_out never locks a fresh chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_ref     <= 1'b0;
      have_prev    <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (on_edge) begin
        have_ref <= 1'b1;
        if (have_ref) begin
          period_out   <= interval;
          period_valid <= 1'b1;
          have_prev    <= 1'b1;
          if (have_prev) begin
            locked <= (abs_diff(interval, period_out) <= TOL_V);
          end
        end
      end else if (timeout) begin
        have_ref  <= 1'b0;
        have_prev <= 1'b0;
        locked    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tremolo_rate_detect.sv
// tb/tb_tremolo_rate_detect.sv - scoreboard bench for tremolo_rate_detect
module tb_tremolo_rate_detect;

  localparam int MZ   = 4;
  localparam int TL   = 2;
  localparam int MAXV = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] audio_in;
  logic [24:0] period_out;
  logic        period_valid, locked, gated;

  always #5 clk = ~clk;

  tremolo_rate_detect #(
    .MIN_ZERO     (MZ),
    .TOL          (TL),
    .INTERVAL_MAX (25'(MAXV))
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_in     (audio_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .gated        (gated)
  );

  typedef struct {
    bit gated;
    bit locked;
    bit pv;
    int period;
  } exp_t;

  exp_t st_q[$];
  int   meas_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Reference model: timestamps of on-edges instead of a running counter.
  longint cyc = 0;
  longint last_edge = 0;
  int     zlen = 0;
  bit     m_off, m_ref, m_prev, m_lock;
  int     m_period;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [23:0] a);
    longint iv;
    bit     edge_now;
    exp_t   e;
    @(negedge clk);
    reset    = r;
    audio_in = a;
    e.pv     = 1'b0;
    if (r) begin
      zlen = 0; m_off = 0; m_ref = 0; m_prev = 0; m_lock = 0; m_period = 0;
      last_edge = cyc;
    end else begin
      iv = cyc - last_edge - 1;
      if (iv > MAXV) iv = MAXV;
      edge_now = m_off && (a != 0);
      zlen = (a == 0) ? zlen + 1 : 0;
      if (edge_now) begin
        if (m_ref) begin
          if (m_prev) m_lock = ((iv > m_period) ? iv - m_period : m_period - iv) <= TL;
          m_period = int'(iv);
          m_prev = 1;
          e.pv = 1'b1;
          meas_q.push_back(int'(iv));
        end
        m_ref = 1;
        last_edge = cyc;
        m_off = 0;
      end else if (iv == MAXV) begin
        m_ref = 0; m_prev = 0; m_lock = 0;
      end
      if (a == 0 && zlen >= MZ) m_off = 1;
    end
    cyc++;
    e.gated  = m_off;
    e.locked = m_lock;
    e.period = m_period;
    st_q.push_back(e);
  endtask

  function automatic logic [23:0] rnd_nz();
    return 24'($urandom_range(32'hFFFFFF, 1));
  endfunction

  // One gating period: zeros then non-zero audio, with optional short silent dips.
  task automatic seg(input int zeros, input int ons, input bit dips);
    int dip_left = 0;
    bit last_zero = 0;
    repeat (zeros) step(0, 24'h0);
    for (int i = 0; i < ons; i++) begin
      if (dip_left > 0) begin
        dip_left--;
        step(0, 24'h0);
        last_zero = 1;
      end else if (dips && !last_zero && i >= 5 && i < ons - 8 && $urandom_range(0, 7) == 0) begin
        dip_left = $urandom_range(MZ - 1, 1) - 1;
        step(0, 24'h0);
        last_zero = 1;
      end else begin
        step(0, ($urandom_range(0, 1) == 0) ? 24'h100000 : rnd_nz());
        last_zero = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        cur = st_q.pop_front();
        check("gated", gated, cur.gated);
        check("locked", locked, cur.locked);
        check("period_valid", period_valid, cur.pv);
        check("period_out", period_out, cur.period);
        if (period_valid) begin
          if (meas_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL meas @%0t: got pulse with period %0d expected no pulse", $time, period_out);
          end else begin
            check("meas", period_out, meas_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    audio_in = 24'h0;
    repeat (3) step(1, 24'h0);
    repeat (20) step(0, 24'h0);
    repeat (5) seg(50, 50, 1);
    repeat (3) seg(100, 100, 1);
    repeat (3) seg(50, 50, 1);
    repeat (MAXV + 50) step(0, rnd_nz());
    repeat (3) seg(50, 50, 1);
    seg(50, 20, 0);
    repeat (2) step(1, rnd_nz());
    repeat (4) seg(50, 50, 1);
    repeat (3) seg(10, MAXV + 1 - 10, 0);
    repeat (60) seg($urandom_range(MZ + 8, MZ - 1), $urandom_range(40, 1), 0);
    repeat (3) step(0, 24'h0);
    repeat (2) @(posedge clk);
    #2;
    check("st_q_drained", st_q.size(), 0);
    check("meas_q_drained", meas_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
